k12_nonce_scheduler: RTL and testbench

- Job-level controller that sequences the K12 PoW datapath (`K12_PoW`) over a nonce range.
- Accepts a job (blob, target, start nonce, count) and issues one hasher load per nonce. After a fixed latency it samples the hasher's hit flag and presents each hit (nonce, hash) on a ready/valid result port.
- Sits between the host/job interface and the single `K12_PoW` instance. It is the hasher's only driver.

---
 rtl/k12_sched_pkg.sv | 27 ++
 rtl/k12_latency_timer.sv | 38 +++
 rtl/k12_nonce_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_k12_nonce_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k12_sched_pkg.sv
// k12_sched_pkg
// Shared definitions for the K12 nonce scheduler: the FSM state encoding,
// datapath widths, the default hasher latency and the latency timer width.
// No ports; imported by k12_latency_timer and k12_nonce_scheduler.
package k12_sched_pkg;

    localparam int BLOB_W               = 576;
    localparam int NONCE_W              = 64;
    localparam int HASH_W               = 256;
    localparam int TARGET_W             = 64;
    localparam int DEFAULT_HASH_LATENCY = 13;
    localparam int TIMER_W              = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        EMIT  = 3'd4
    } state_t;

    // Nonce sequence step; wraps modulo 2^64.
    function automatic logic [NONCE_W-1:0] next_nonce(input logic [NONCE_W-1:0] n);
        return n + 64'd1;
    endfunction

endpackage

// File: rtl/k12_latency_timer.sv
// k12_latency_timer
// Loadable 8-bit down-counter with a zero flag. Counts down while dec is
// high and holds at zero.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        load load_value this cycle (wins over dec)
//   load_value  value to load
//   dec         decrement enable
//   zero        counter currently equals zero
module k12_latency_timer
    import k12_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count_r;

    // Down-counter register with load priority and saturation at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != 8'd0)) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 8'd0);

endmodule

// File: rtl/k12_nonce_scheduler.sv
// k12_nonce_scheduler
// Job-level controller for a single K12_PoW hasher. Accepts a job (blob,
// target, start nonce, count), issues one hash_load per nonce, samples the
// hit flag HASH_LATENCY cycles later and presents hits on a ready/valid port.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   job_*                        job handshake and job contents
//   abort                        cancel the running job
//   hash_rst/load/blob/target/nonce  hasher drive
//   hash_store/hash_out          hasher hit flag and hash
//   res_*                        hit result handshake (nonce, hash)
//   busy, done                   job in progress / one-cycle completion pulse
//   hash_count, hit_count        statistics counters
// Build option: define K12_SCHED_STATS_EN to build the saturating hash/hit
// counters; otherwise both counter outputs are tied to zero.
module k12_nonce_scheduler
    import k12_sched_pkg::*;
#(
    parameter int HASH_LATENCY = DEFAULT_HASH_LATENCY,
    parameter int COUNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [BLOB_W-1:0]   job_blob,
    input  logic [TARGET_W-1:0] job_target,
    input  logic [NONCE_W-1:0]  job_nonce_start,
    input  logic [COUNT_W-1:0]  job_nonce_count,
    input  logic                abort,
    output logic                hash_rst,
    output logic                hash_load,
    output logic [BLOB_W-1:0]   hash_blob,
    output logic [TARGET_W-1:0] hash_target,
    output logic [NONCE_W-1:0]  hash_nonce,
    input  logic                hash_store,
    input  logic [HASH_W-1:0]   hash_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NONCE_W-1:0]  res_nonce,
    output logic [HASH_W-1:0]   res_hash,
    output logic                busy,
    output logic                done,
    output logic [47:0]         hash_count,
    output logic [15:0]         hit_count
);

    // Timer holds HASH_LATENCY-1 during LOAD and reaches zero in the last
    // WAIT cycle, so CHECK lands exactly HASH_LATENCY cycles after LOAD.
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(HASH_LATENCY - 1);

    state_t               state_r;
    logic [BLOB_W-1:0]    blob_r;
    logic [TARGET_W-1:0]  target_r;
    logic [NONCE_W-1:0]   nonce_r;
    logic [COUNT_W-1:0]   remaining_r;
    logic                 hash_load_r;
    logic                 res_valid_r;
    logic                 done_r;
    logic                 abort_rst_r;
    logic [NONCE_W-1:0]   res_nonce_r;
    logic [HASH_W-1:0]    res_hash_r;

    logic accept_s;
    logic advance_s;
    logic last_s;
    logic enter_load_s;
    logic timer_dec_s;
    logic timer_zero_s;

    // Next-step decode shared by the FSM and the latency timer.
    always_comb begin
        accept_s     = (state_r == IDLE) && job_valid && !rst;
        advance_s    = !abort && (((state_r == CHECK) && !hash_store) ||
                                  ((state_r == EMIT) && res_ready));
        last_s       = (remaining_r == {{(COUNT_W-1){1'b0}}, 1'b1});
        enter_load_s = !rst && ((accept_s && (job_nonce_count != {COUNT_W{1'b0}})) ||
                                (advance_s && !last_s));
        timer_dec_s  = (state_r == LOAD) || (state_r == WAIT);
    end

    k12_latency_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (enter_load_s),
        .load_value (TIMER_INIT),
        .dec        (timer_dec_s),
        .zero       (timer_zero_s)
    );

    // Job sequencing FSM with registered hasher and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            blob_r      <= {BLOB_W{1'b0}};
            target_r    <= {TARGET_W{1'b0}};
            nonce_r     <= {NONCE_W{1'b0}};
            remaining_r <= {COUNT_W{1'b0}};
            hash_load_r <= 1'b0;
            res_valid_r <= 1'b0;
            done_r      <= 1'b0;
            abort_rst_r <= 1'b0;
            res_nonce_r <= {NONCE_W{1'b0}};
            res_hash_r  <= {HASH_W{1'b0}};
        end else begin
            hash_load_r <= enter_load_s;
            done_r      <= 1'b0;
            abort_rst_r <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                // Abort beats a CHECK hit and a same-cycle res_ready.
                state_r     <= IDLE;
                done_r      <= 1'b1;
                abort_rst_r <= 1'b1;
                res_valid_r <= 1'b0;
            end else if (advance_s) begin
                nonce_r     <= next_nonce(nonce_r);
                remaining_r <= remaining_r - {{(COUNT_W-1){1'b0}}, 1'b1};
                res_valid_r <= 1'b0;
                if (last_s) begin
                    state_r <= IDLE;
                    done_r  <= 1'b1;
                end else begin
                    state_r <= LOAD;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (job_valid) begin
                            blob_r      <= job_blob;
                            target_r    <= job_target;
                            nonce_r     <= job_nonce_start;
                            remaining_r <= job_nonce_count;
                            if (job_nonce_count == {COUNT_W{1'b0}}) begin
                                done_r  <= 1'b1;
                                state_r <= IDLE;
                            end else begin
                                state_r <= LOAD;
                            end
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    LOAD:  state_r <= WAIT;
                    WAIT:  state_r <= timer_zero_s ? CHECK : WAIT;
                    CHECK: begin
                        // Only reached with hash_store high: a no-hit CHECK advances.
                        res_hash_r  <= hash_out;
                        res_nonce_r <= nonce_r;
                        res_valid_r <= 1'b1;
                        state_r     <= EMIT;
                    end
                    EMIT:  state_r <= EMIT;
                    default: begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign job_ready   = (state_r == IDLE) && !rst;
    assign hash_rst    = rst || abort_rst_r;
    assign hash_load   = hash_load_r;
    assign hash_blob   = blob_r;
    assign hash_target = target_r;
    assign hash_nonce  = nonce_r;
    assign res_valid   = res_valid_r;
    assign res_nonce   = res_nonce_r;
    assign res_hash    = res_hash_r;
    assign busy        = (state_r != IDLE);
    assign done        = done_r;

`ifdef K12_SCHED_STATS_EN
    logic [47:0] hash_count_r;
    logic [15:0] hit_count_r;
    logic        xfer_s;

    assign xfer_s = (state_r == EMIT) && res_valid_r && res_ready && !abort;

    // Saturating statistics counters; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_count_r <= 48'd0;
            hit_count_r  <= 16'd0;
        end else begin
            if (hash_load_r && (hash_count_r != {48{1'b1}})) begin
                hash_count_r <= hash_count_r + 48'd1;
            end else begin
                hash_count_r <= hash_count_r;
            end
            if (xfer_s && (hit_count_r != {16{1'b1}})) begin
                hit_count_r <= hit_count_r + 16'd1;
            end else begin
                hit_count_r <= hit_count_r;
            end
        end
    end

    assign hash_count = hash_count_r;
    assign hit_count  = hit_count_r;
`else
    assign hash_count = 48'd0;
    assign hit_count  = 16'd0;
`endif

endmodule

// File: tb/tb_k12_nonce_scheduler.sv
// tb_k12_nonce_scheduler
// Self-checking bench: a latency-accurate hasher model feeds the scheduler,
// and each job is checked against a per-nonce timeline (load, HASH_LATENCY
// quiet cycles, optional result hold, completion) derived from the job.
module tb_k12_nonce_scheduler;

    localparam int LAT = 13;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [575:0] job_blob = '0;
    logic [63:0]  job_target = '0;
    logic [63:0]  job_nonce_start = '0;
    logic [31:0]  job_nonce_count = '0;
    logic         abort = 1'b0;
    logic         hash_rst;
    logic         hash_load;
    logic [575:0] hash_blob;
    logic [63:0]  hash_target;
    logic [63:0]  hash_nonce;
    logic         hash_store;
    logic [255:0] hash_out;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [63:0]  res_nonce;
    logic [255:0] res_hash;
    logic         busy;
    logic         done;
    logic [47:0]  hash_count;
    logic [15:0]  hit_count;

    int checks = 0;
    int failures = 0;
    int hit_mode = 0;
    int exp_hash_cnt = 0;
    int exp_hit_cnt = 0;

    always #5 clk = ~clk;

    k12_nonce_scheduler dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_blob(job_blob), .job_target(job_target),
        .job_nonce_start(job_nonce_start), .job_nonce_count(job_nonce_count),
        .abort(abort), .hash_rst(hash_rst), .hash_load(hash_load),
        .hash_blob(hash_blob), .hash_target(hash_target), .hash_nonce(hash_nonce),
        .hash_store(hash_store), .hash_out(hash_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_nonce(res_nonce), .res_hash(res_hash),
        .busy(busy), .done(done), .hash_count(hash_count), .hit_count(hit_count)
    );

    // Hash value the modelled hasher produces for a nonce.
    function automatic logic [255:0] model_hash(input logic [63:0] n);
        return {n ^ 64'hA5A5_5A5A_0F0F_F0F0, n * 64'h0000_0001_0000_01B3,
                ~n, n + 64'h1357_9BDF_2468_ACE0};
    endfunction

    // Hit rule: 0 never, 1 always, 2 pseudo-random, 3 even nonces.
    function automatic logic is_hit(input logic [63:0] n, input int mode);
        logic [63:0] p;
        p = n * 64'h9E37_79B9_7F4A_7C15;
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (p[63:61] < 3'd3);
            default: return ~n[0];
        endcase
    endfunction

    // Hasher model: the nonce loaded in cycle L is reported in cycle L+LAT.
    logic [LAT-1:0] pv = '0;
    logic [63:0]    pn [LAT];
    always @(posedge clk) begin
        if (hash_rst) begin
            pv <= '0;
        end else begin
            pv <= {pv[LAT-2:0], hash_load};
            pn[0] <= hash_nonce;
            for (int i = 1; i < LAT; i++) pn[i] <= pn[i-1];
        end
    end
    assign hash_store = pv[LAT-1] & is_hit(pn[LAT-1], hit_mode);
    assign hash_out   = pv[LAT-1] ? model_hash(pn[LAT-1]) : {8{32'hDEAD_BEEF}};

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef K12_SCHED_STATS_EN
        check_val({tag, "_hash_count"}, 256'(hash_count), 256'(exp_hash_cnt));
        check_val({tag, "_hit_count"}, 256'(hit_count), 256'(exp_hit_cnt));
`else
        check_val({tag, "_hash_count"}, 256'(hash_count), 256'd0);
        check_val({tag, "_hit_count"}, 256'(hit_count), 256'd0);
`endif
    endtask

    // Drive one job through acceptance; returns in the first sampled cycle after it.
    task automatic accept_job(input logic [63:0] start, input logic [31:0] count,
                              input int mode, input bit abort_too,
                              output logic [575:0] blob, output logic [63:0] tgt);
        for (int i = 0; i < 18; i++) blob[i*32 +: 32] = $urandom;
        tgt = {$urandom, $urandom};
        hit_mode = mode;
        check_val("job_ready_idle", 256'(job_ready), 256'd1);
        job_valid = 1'b1;
        job_blob = blob;
        job_target = tgt;
        job_nonce_start = start;
        job_nonce_count = count;
        abort = abort_too;
        tick();
        job_valid = 1'b0;
        abort = 1'b0;
    endtask

    // Full job with timeline checks; delay<0 picks random result backpressure.
    task automatic run_job(input logic [63:0] start, input logic [31:0] count,
                           input int mode, input bit abort_too, input int delay);
        logic [575:0] blob;
        logic [63:0]  tgt;
        logic [63:0]  n;
        int           d;
        accept_job(start, count, mode, abort_too, blob, tgt);
        if (count == 32'd0) begin
            check_val("zero_done", 256'(done), 256'd1);
            check_val("zero_no_load", 256'(hash_load), 256'd0);
            check_val("zero_busy", 256'(busy), 256'd0);
            tick();
            check_val("zero_done_clear", 256'(done), 256'd0);
            check_val("zero_no_load2", 256'(hash_load), 256'd0);
            return;
        end
        n = start;
        for (int unsigned i = 0; i < count; i++) begin
            check_val("load_pulse", 256'(hash_load), 256'd1);
            check_val("load_nonce", 256'(hash_nonce), 256'(n));
            check_val("load_blob", 256'(hash_blob === blob), 256'd1);
            check_val("load_target", 256'(hash_target), 256'(tgt));
            check_val("load_busy", 256'(busy), 256'd1);
            check_val("load_done", 256'(done), 256'd0);
            check_val("load_hash_rst", 256'(hash_rst), 256'd0);
            exp_hash_cnt++;
            for (int k = 1; k <= LAT; k++) begin
                tick();
                check_val("wait_no_load", 256'(hash_load), 256'd0);
                check_val("wait_no_valid", 256'(res_valid), 256'd0);
                check_val("wait_nonce_stable", 256'(hash_nonce), 256'(n));
                if (k == 1) check_stats("after_load");
            end
            tick();
            if (is_hit(n, mode)) begin
                d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
                for (int k = 0; k <= d; k++) begin
                    check_val("emit_valid", 256'(res_valid), 256'd1);
                    check_val("emit_nonce", 256'(res_nonce), 256'(n));
                    check_val("emit_hash", res_hash, model_hash(n));
                    check_val("emit_no_load", 256'(hash_load), 256'd0);
                    if (k == d) res_ready = 1'b1;
                    tick();
                end
                res_ready = 1'b0;
                exp_hit_cnt++;
            end
            n = n + 64'd1;
        end
        check_val("job_done", 256'(done), 256'd1);
        check_val("job_idle_busy", 256'(busy), 256'd0);
        check_val("job_idle_ready", 256'(job_ready), 256'd1);
        check_val("job_idle_no_load", 256'(hash_load), 256'd0);
        check_val("job_idle_no_valid", 256'(res_valid), 256'd0);
        tick();
        check_val("job_done_clear", 256'(done), 256'd0);
        check_stats("job_end");
    endtask

    task automatic check_abort_cycle(input string tag);
        check_val({tag, "_done"}, 256'(done), 256'd1);
        check_val({tag, "_hash_rst"}, 256'(hash_rst), 256'd1);
        check_val({tag, "_res_valid"}, 256'(res_valid), 256'd0);
        check_val({tag, "_job_ready"}, 256'(job_ready), 256'd1);
        check_val({tag, "_no_load"}, 256'(hash_load), 256'd0);
        tick();
        check_val({tag, "_done_clear"}, 256'(done), 256'd0);
        check_val({tag, "_hash_rst_clear"}, 256'(hash_rst), 256'd0);
        check_val({tag, "_no_load_after"}, 256'(hash_load), 256'd0);
        check_stats(tag);
    endtask

    initial begin
        logic [575:0] blob;
        logic [63:0]  tgt;
        logic [63:0]  start;

        // Power-on reset.
        tick();
        check_val("rst_hash_rst", 256'(hash_rst), 256'd1);
        check_val("rst_job_ready", 256'(job_ready), 256'd0);
        tick();
        rst = 1'b0;
        tick();
        check_val("reset_hash_load", 256'(hash_load), 256'd0);
        check_val("reset_res_valid", 256'(res_valid), 256'd0);
        check_val("reset_busy", 256'(busy), 256'd0);
        check_val("reset_done", 256'(done), 256'd0);
        check_val("reset_hash_nonce", 256'(hash_nonce), 256'd0);
        check_val("reset_res_nonce", 256'(res_nonce), 256'd0);
        check_val("reset_res_hash", res_hash, 256'd0);
        check_val("reset_hash_rst", 256'(hash_rst), 256'd0);
        check_val("reset_job_ready", 256'(job_ready), 256'd1);
        check_stats("reset");

        // Three nonces, never a hit.
        run_job(64'h10, 32'd3, 0, 1'b0, 0);
        // Two nonces, hit on the first, result held back five cycles.
        run_job(64'h100, 32'd2, 3, 1'b0, 5);
        // Nonce wraps from all-ones to zero.
        run_job(64'hFFFF_FFFF_FFFF_FFFF, 32'd2, 0, 1'b0, 0);
        // Empty job.
        run_job(64'h55, 32'd0, 0, 1'b0, 0);
        // abort with job_valid in IDLE is ignored.
        run_job(64'h200, 32'd1, 1, 1'b1, 1);

        // Abort during WAIT of the second nonce.
        accept_job(64'h300, 32'd3, 0, 1'b0, blob, tgt);
        for (int k = 0; k < LAT + 1; k++) tick();
        check_val("abort_wait_second_load", 256'(hash_load), 256'd1);
        for (int k = 0; k < 4; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_hash_cnt += 2;
        check_abort_cycle("abort_wait");

        // Abort during EMIT, together with res_ready.
        accept_job(64'h400, 32'd2, 1, 1'b0, blob, tgt);
        for (int k = 0; k < LAT + 1; k++) tick();
        check_val("abort_emit_valid", 256'(res_valid), 256'd1);
        tick();
        tick();
        abort = 1'b1;
        res_ready = 1'b1;
        tick();
        abort = 1'b0;
        res_ready = 1'b0;
        exp_hash_cnt += 1;
        check_abort_cycle("abort_emit");

        // Reset in the middle of WAIT.
        accept_job(64'h500, 32'd3, 0, 1'b0, blob, tgt);
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        check_val("midrst_hash_rst", 256'(hash_rst), 256'd1);
        check_val("midrst_job_ready", 256'(job_ready), 256'd0);
        check_val("midrst_busy", 256'(busy), 256'd0);
        check_val("midrst_done", 256'(done), 256'd0);
        check_val("midrst_no_load", 256'(hash_load), 256'd0);
        check_val("midrst_nonce", 256'(hash_nonce), 256'd0);
        check_val("midrst_blob", 256'(hash_blob === 576'd0), 256'd1);
        tick();
        check_val("midrst_hash_rst2", 256'(hash_rst), 256'd1);
        rst = 1'b0;
        exp_hash_cnt = 0;
        exp_hit_cnt = 0;
        tick();
        check_val("postrst_done", 256'(done), 256'd0);
        check_val("postrst_hash_rst", 256'(hash_rst), 256'd0);
        check_val("postrst_job_ready", 256'(job_ready), 256'd1);
        check_stats("postrst");
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            check_val("postrst_quiet_load", 256'(hash_load), 256'd0);
            check_val("postrst_quiet_valid", 256'(res_valid), 256'd0);
        end

        // Randomized jobs.
        for (int j = 0; j < 16; j++) begin
            start = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) start = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
            run_job(start, 32'($urandom_range(0, 4)), 2, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
